// File: rtl/rom_streamer.sv
// Address sequencer and valid/ready stream adapter for a 1-cycle-latency 8-bit ROM.
// Optional XOR checksum of accepted beats enabled by defining ROM_STREAMER_CSUM_EN.
module rom_streamer #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic [DW-1:0] csum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t          state_r;
   logic [AW-1:0]   addr_r;
   logic [AW:0]     issue_cnt_r;
   logic [AW:0]     accept_cnt_r;
   logic            rd_pend_r;
   logic [DW-1:0]   fifo_r [2];
   logic            wr_ptr_r;
   logic            rd_ptr_r;
   logic [1:0]      fifo_cnt_r;
   logic            busy_r;
   logic            done_r;

   logic            pop_s;
   logic            push_s;
   logic            issue_s;
   logic [2:0]      occ_s;

   // Handshake and issue decision; occupancy counts the read still in flight.
   always_comb begin
      pop_s   = (fifo_cnt_r != 2'd0) & m_ready;
      push_s  = rd_pend_r;
      occ_s   = {1'b0, fifo_cnt_r} + {2'b00, rd_pend_r};
      issue_s = 1'b0;
      if ((state_r == RUN) && (issue_cnt_r != CNT_ZERO) &&
          (occ_s < (3'd2 + {2'b00, pop_s}))) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Command FSM, address/beat counters and the 2-entry capture FIFO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         addr_r       <= {AW{1'b0}};
         issue_cnt_r  <= CNT_ZERO;
         accept_cnt_r <= CNT_ZERO;
         rd_pend_r    <= 1'b0;
         fifo_r[0]    <= {DW{1'b0}};
         fifo_r[1]    <= {DW{1'b0}};
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         fifo_cnt_r   <= 2'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         rd_pend_r <= issue_s;
         if (issue_s) begin
            addr_r      <= addr_r + ADDR_ONE;
            issue_cnt_r <= issue_cnt_r - CNT_ONE;
         end
         if (push_s) begin
            fifo_r[wr_ptr_r] <= rom_data;
            wr_ptr_r         <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r     <= ~rd_ptr_r;
            accept_cnt_r <= accept_cnt_r - CNT_ONE;
         end
         fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};

         case (state_r)
            IDLE: begin
               if (start && (len != CNT_ZERO)) begin
                  addr_r       <= base;
                  issue_cnt_r  <= len;
                  accept_cnt_r <= len;
                  busy_r       <= 1'b1;
                  state_r      <= RUN;
               end else if (start) begin
                  done_r <= 1'b1;
               end
            end
            RUN: begin
               // Zero-count check guards against an impossible stuck RUN.
               if ((issue_s && (issue_cnt_r == CNT_ONE)) || (issue_cnt_r == CNT_ZERO)) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if ((pop_s && (accept_cnt_r == CNT_ONE)) || (accept_cnt_r == CNT_ZERO)) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign rom_addr = addr_r;
   assign m_valid  = (fifo_cnt_r != 2'd0);
   assign m_data   = fifo_r[rd_ptr_r];
   assign m_last   = (fifo_cnt_r != 2'd0) & (accept_cnt_r == CNT_ONE);

`ifdef ROM_STREAMER_CSUM_EN
   function automatic logic [DW-1:0] csum_next(input logic [DW-1:0] acc,
                                               input logic [DW-1:0] beat);
      return acc ^ beat;
   endfunction

   logic [DW-1:0] csum_r;

   // Checksum restarts on every accepted command and folds in each handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         csum_r <= {DW{1'b0}};
      end else if ((state_r == IDLE) && start) begin
         csum_r <= {DW{1'b0}};
      end else if (pop_s) begin
         csum_r <= csum_next(csum_r, fifo_r[rd_ptr_r]);
      end else begin
         csum_r <= csum_r;
      end
   end

   assign csum = csum_r;
`else
   assign csum = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Directed self-checking bench for rom_streamer with a behavioural 1-cycle ROM.
`timescale 1ns/1ps
module tb_rom_streamer;

   logic       clock, reset, start, busy, done, m_valid, m_ready, m_last;
   logic [7:0] base, rom_addr, rom_data, m_data, csum;
   logic [8:0] len;
   logic [7:0] rom [256];
   logic [7:0] exp_q [$];
   int         n_cmp = 0;
   int         n_err = 0;

   rom_streamer #(.AW(8), .DW(8)) dut (
      .clock(clock), .reset(reset), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .csum(csum)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rom_data <= 8'h00;
      else       rom_data <= rom[rom_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] csum_exp(input logic [7:0] v);
`ifdef ROM_STREAMER_CSUM_EN
      return v;
`else
      return 8'h00;
`endif
   endfunction

   task automatic stream_ready(input logic [7:0] b, input logic [8:0] l,
                               input logic [7:0] cs, input string tag);
      @(negedge clock);
      start = 1'b1; base = b; len = l; m_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk({tag, "/busy1"}, 32'(busy), 32'h1);
      chk({tag, "/addr1"}, 32'(rom_addr), 32'(b));
      @(negedge clock);
      chk({tag, "/valid2"}, 32'(m_valid), 32'h0);
      for (int i = 0; i < int'(l); i++) begin
         @(negedge clock);
         chk({tag, "/valid"}, 32'(m_valid), 32'h1);
         chk({tag, "/data"}, 32'(m_data), 32'(exp_q[i]));
         chk({tag, "/last"}, 32'(m_last), 32'(i == int'(l) - 1));
      end
      @(negedge clock);
      chk({tag, "/done"}, 32'(done), 32'h1);
      chk({tag, "/busy_end"}, 32'(busy), 32'h0);
      chk({tag, "/valid_end"}, 32'(m_valid), 32'h0);
      chk({tag, "/csum"}, 32'(csum), 32'(csum_exp(cs)));
      @(negedge clock);
      chk({tag, "/done_drop"}, 32'(done), 32'h0);
   endtask

   initial begin
      int         got, cyc;
      logic       stall, r, pl;
      logic [7:0] pd;

      for (int i = 0; i < 256; i++)
         rom[i] = (i < 16) ? 8'(i * 17) : (8'(i) ^ 8'h5A);
      reset = 1'b1; start = 1'b0; base = 8'h00; len = 9'd0; m_ready = 1'b0;

      @(negedge clock);
      chk("rst/busy", 32'(busy), 32'h0);
      chk("rst/done", 32'(done), 32'h0);
      chk("rst/valid", 32'(m_valid), 32'h0);
      chk("rst/addr", 32'(rom_addr), 32'h0);
      chk("rst/csum", 32'(csum), 32'h0);
      reset = 1'b0;

      // 16 ascending beats, ready held high
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i * 17));
      stream_ready(8'd0, 9'd16, 8'h00, "seq16");

      // address wrap 254,255,0,1
      exp_q = '{8'hA4, 8'hA5, 8'h00, 8'h11};
      stream_ready(8'd254, 9'd4, 8'h10, "wrap");

      // random backpressure on the 16-beat command
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i * 17));
      @(negedge clock);
      start = 1'b1; base = 8'd0; len = 9'd16; m_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      got = 0; cyc = 0; stall = 1'b0; pd = 8'h00; pl = 1'b0;
      while (got < 16 && cyc < 300) begin
         if (stall) begin
            chk("bp/hold_valid", 32'(m_valid), 32'h1);
            chk("bp/hold_data", 32'(m_data), 32'(pd));
            chk("bp/hold_last", 32'(m_last), 32'(pl));
         end
         r = 1'($urandom_range(0, 1));
         m_ready = r;
         if (m_valid && r) begin
            chk("bp/data", 32'(m_data), 32'(exp_q[got]));
            chk("bp/last", 32'(m_last), 32'(got == 15));
            got++;
            stall = 1'b0;
         end else if (m_valid) begin
            stall = 1'b1; pd = m_data; pl = m_last;
         end else begin
            stall = 1'b0;
         end
         cyc++;
         if (got < 16) @(negedge clock);
      end
      @(negedge clock);
      m_ready = 1'b1;
      chk("bp/count", 32'(got), 32'd16);
      chk("bp/done", 32'(done), 32'h1);
      chk("bp/busy", 32'(busy), 32'h0);
      chk("bp/csum", 32'(csum), 32'(csum_exp(8'h00)));

      // zero-length command
      @(negedge clock);
      start = 1'b1; base = 8'h33; len = 9'd0;
      @(negedge clock);
      start = 1'b0;
      chk("len0/done", 32'(done), 32'h1);
      chk("len0/busy", 32'(busy), 32'h0);
      chk("len0/valid", 32'(m_valid), 32'h0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         chk("len0/done_after", 32'(done), 32'h0);
         chk("len0/busy_after", 32'(busy), 32'h0);
         chk("len0/valid_after", 32'(m_valid), 32'h0);
      end

      // full 256-beat window
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(rom[i]);
      stream_ready(8'd0, 9'd256, 8'h00, "len256");

      // start while busy is ignored
      @(negedge clock);
      start = 1'b1; base = 8'd0; len = 9'd8; m_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("ign/busy", 32'(busy), 32'h1);
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("ign/valid", 32'(m_valid), 32'h1);
         chk("ign/data", 32'(m_data), 32'(8'(i * 17)));
         chk("ign/last", 32'(m_last), 32'(i == 7));
         if (i == 1) begin start = 1'b1; base = 8'd5; len = 9'd3; end
         else        start = 1'b0;
      end
      @(negedge clock);
      chk("ign/done", 32'(done), 32'h1);
      chk("ign/csum", 32'(csum), 32'(csum_exp(8'h00)));
      @(negedge clock);
      chk("ign/busy_end", 32'(busy), 32'h0);
      chk("ign/valid_end", 32'(m_valid), 32'h0);

      // reset after 3 accepted beats
      @(negedge clock);
      start = 1'b1; base = 8'd0; len = 9'd16; m_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("mid/data", 32'(m_data), 32'(8'(i * 17)));
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid/busy", 32'(busy), 32'h0);
      chk("mid/valid", 32'(m_valid), 32'h0);
      chk("mid/data0", 32'(m_data), 32'h0);
      chk("mid/addr", 32'(rom_addr), 32'h0);
      @(negedge clock);
      chk("mid/last", 32'(m_last), 32'h0);
      chk("mid/done", 32'(done), 32'h0);
      chk("mid/csum", 32'(csum), 32'h0);
      reset = 1'b0;
      exp_q = '{8'h22, 8'h33};
      stream_ready(8'd2, 9'd2, 8'h11, "post_rst");
      @(negedge clock);
      chk("post_rst/quiet", 32'(m_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rom_streamer.md
# rom_streamer

Address sequencer and stream adapter placed directly in front of the single-port 8-bit ROM block (RAMB18E2, `addr[7:0]` in, `data[7:0]` out, one-cycle registered read latency). On a `start` command it walks a contiguous address window, issues one ROM read per cycle and absorbs the read latency. It also handles downstream backpressure and presents the fetched bytes as a valid/ready stream with a last-beat marker. It replaces ad-hoc counters that currently drive the ROM address directly.

## Interface
Parameters:
- `AW`, 8, ROM address width; must match ROM `addr`.
- `DW`, 8, ROM data width; must match ROM `data`.

Ports:
- `clock`  in  1  single clock, shared with the ROM.
- `reset`  in  1  asynchronous, active-high reset; the ROM's reset is tied to the same net.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base`  in  AW  first address; sampled with `start`.
- `len`  in  AW+1  beat count, 0..256; sampled with `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when a command completes.
- `rom_addr`  out  AW  to ROM `addr`.
- `rom_data`  in  DW  from ROM `data`; valid the cycle after `rom_addr`.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_data`  out  DW  stream byte.
- `m_last`  out  1  high on the final beat.
- `csum`  out  DW  XOR checksum of accepted beats. See Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 and `len`≠0: latch `base` into the address counter, latch `len` into the issue and accept counters, go to RUN.
  - `start`=1 and `len`=0: pulse `done` in the next cycle and stay in IDLE; no beats are produced.
- RUN issue rule:
  - A read issues in a cycle when the issue counter is ≠0 and `fifo_count + rd_pend − pop < 2`.
  - `pop` = `m_valid & m_ready`.
  - `rd_pend` = a read issued in the previous cycle.
  - On issue, the address counter increments modulo 2^AW; 255→0 wraps silently. The issue counter decrements.
- `rom_addr` equals the address counter at all times. The ROM always reads, so non-issue cycles produce don't-care data, which is discarded.
- Capture: when `rd_pend`=1, `rom_data` is pushed into a 2-entry FIFO. This can never overflow, by the issue rule.
- Stream: `m_valid` = FIFO not empty; `m_data` = FIFO head; `m_last` = (accept counter == 1) & `m_valid`.
- Each pop decrements the accept counter.
- RUN→DRAIN when the issue counter reaches 0. DRAIN→IDLE when the accept counter reaches 0, with `done` pulsed in the following cycle.
- `start` while `busy`: ignored; the latched command is unaffected.
- Once `m_valid`=1, `m_data` and `m_last` are held stable until the beat is accepted (AXI-stream rule). `m_valid` does not drop without a pop.
- Reset, whether idle or mid-command:
  - All of the following go to 0: state, counters, FIFO, `busy`, `done`, `m_valid`, `m_last`, `m_data`, `rom_addr`, `csum`.
  - An in-flight read is discarded.

## Timing
- `start` high in cycle 0 gives:
  - cycle 1: `busy`=1, `rom_addr`=`base`
  - cycle 2: `rom_data`=ROM[`base`]
  - cycle 3: `m_valid`=1 with that byte
- With `m_ready` held high, throughput is 1 beat/cycle and `len` beats occupy cycles 3..len+2.
- `done` is high in the cycle after the last handshake; `busy` is 0 in that same cycle.
- Backpressure: at most 2 bytes are buffered; issue resumes the cycle a pop makes room.
- Back-to-back commands: `start` is accepted in the cycle `done` is high. Minimum gap between commands is 1 cycle.

## Configuration
- `ROM_STREAMER_CSUM_EN` defined:
  - `csum` clears to 0 when a command is accepted.
  - On every handshake, `csum ^= m_data`.
  - The value is held after `done` until the next accepted `start` or reset.
- `ROM_STREAMER_CSUM_EN` undefined: `csum` is tied to 0 and no checksum register is built. The port list is unchanged.

## Test plan
- ROM initialised 0x00,0x11,…,0xFF at addresses 0..15; `base`=0, `len`=16, `m_ready`=1:
  - 16 beats 0x00..0xFF on consecutive cycles 3..18
  - `m_last` on 0xFF
  - `done` in cycle 19
  - `csum`=0x00 with the macro defined
- `base`=254, `len`=4: beats are ROM[254], ROM[255], ROM[0], ROM[1], confirming address wrap.
- Same command as the first scenario with `m_ready` toggled randomly (50%):
  - identical byte sequence, none dropped or duplicated
  - `m_data` stable while `m_valid` & !`m_ready`
  - FIFO occupancy never above 2
- `len`=0: `done` pulses in cycle 1, `m_valid` never rises, `busy` stays 0. `len`=256 from `base`=0: exactly 256 beats.
- Re-assert `start` with `base`=5 in cycle 4 of a `len`=8 command: the new `start` is ignored and the original 8 beats complete.
- Assert `reset` for 1 cycle after 3 beats of a 16-beat command: all outputs are 0 in the next cycle, and a new `start` with `base`=2, `len`=2 gives ROM[2], ROM[3] only.
